accumulator_2x2: RTL and testbench

- Accumulates a 2x2 block of IEEE-754 binary32 values into four running-sum registers. Used by the block matrix multiplier to sum partial 2x2 products.
- Each accepted start adds the four input words to the four accumulators in parallel, using four identical internal floating-point adder lanes.
- Pulses done when the new sums are visible on the outputs.

---
 rtl/accumulator_2x2.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_accumulator_2x2.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_2x2.sv
// 2x2 binary32 accumulator: four running sums updated in parallel per start,
// using four identical pipelined floating-point adder lanes.

module fp_add_lane #(
    parameter int ADD_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        launch,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        result_ready
);
    // Unpack, align and add are one stage each. The normalize/round/pack
    // result then runs through a delay line, so that result_ready rises
    // exactly ADD_LAT edges after the launch edge.
    localparam int DLY = ADD_LAT - 2;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic        sp_hit;
    logic [31:0] sp_val;

    logic        s1_valid, s1_sign, s1_sub, s1_sp_hit;
    logic [7:0]  s1_exp, s1_diff;
    logic [23:0] s1_mbig, s1_msml;
    logic [31:0] s1_sp_val;

    logic [26:0] ext, shifted, lost, aligned;

    logic        s2_valid, s2_sign, s2_sub, s2_sp_hit;
    logic [7:0]  s2_exp;
    logic [26:0] s2_big, s2_sml;
    logic [31:0] s2_sp_val;

    logic        s3_valid, s3_sign, s3_sp_hit;
    logic [7:0]  s3_exp;
    logic [27:0] s3_sum;
    logic [31:0] s3_sp_val;

    logic [4:0]        lz;
    logic              found;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       rounded;
    logic [22:0]       frac;
    logic [31:0]       packed_val;

    logic [31:0]    dly_val [DLY];
    logic [DLY-1:0] dly_vld;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    // Subnormal operands have a zero exponent field and are treated as zero.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_big  = ({ea, fa} >= {eb, fb});

    always_comb begin
        sp_hit = 1'b1;
        sp_val = 32'h0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sp_val = QNAN;
        end else if (a_inf) begin
            sp_val = a;
        end else if (b_inf) begin
            sp_val = b;
        end else if (a_zero && b_zero) begin
            sp_val = {sa & sb, 31'd0};
        end else if (a_zero) begin
            sp_val = b;
        end else if (b_zero) begin
            sp_val = a;
        end else begin
            sp_hit = 1'b0;
        end
    end

    always_comb begin
        ext     = {s1_msml, 3'b000};
        shifted = 27'd0;
        lost    = 27'd0;
        aligned = 27'd1;
        if (s1_diff < 8'd27) begin
            shifted = ext >> s1_diff;
            lost    = ext & ~(27'h7FF_FFFF << s1_diff);
            aligned = {shifted[26:1], shifted[0] | (|lost)};
        end
    end

    always_comb begin
        lz         = 5'd0;
        found      = 1'b0;
        norm       = 27'd0;
        exp_n      = 10'sd0;
        exp_r      = 10'sd0;
        round_up   = 1'b0;
        rounded    = 25'd0;
        frac       = 23'd0;
        packed_val = 32'h0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && s3_sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (s3_sum[27]) begin
            norm  = {s3_sum[27:2], s3_sum[1] | s3_sum[0]};
            exp_n = $signed({2'b00, s3_exp}) + 10'sd1;
        end else begin
            norm  = s3_sum[26:0] << lz;
            exp_n = $signed({2'b00, s3_exp}) - $signed({5'b00000, lz});
        end
        // Round to nearest, ties to even; norm[2:0] are guard/round/sticky.
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rounded[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = rounded[23:1];
        end else begin
            exp_r = exp_n;
            frac  = rounded[22:0];
        end
        if (s3_sp_hit) begin
            packed_val = s3_sp_val;
        end else if (s3_sum == 28'd0) begin
            packed_val = 32'h0;
        end else if (exp_r >= 10'sd255) begin
            packed_val = {s3_sign, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            packed_val = 32'h0;
        end else begin
            packed_val = {s3_sign, exp_r[7:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            dly_vld  <= '0;
        end else begin
            s1_valid   <= launch;
            s2_valid   <= s1_valid;
            s3_valid   <= s2_valid;
            dly_vld[0] <= s3_valid;
            for (int i = 1; i < DLY; i++) begin
                dly_vld[i] <= dly_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_sign   <= a_big ? sa : sb;
        s1_sub    <= sa ^ sb;
        s1_exp    <= a_big ? ea : eb;
        s1_diff   <= a_big ? (ea - eb) : (eb - ea);
        s1_mbig   <= {1'b1, a_big ? fa : fb};
        s1_msml   <= {1'b1, a_big ? fb : fa};
        s1_sp_hit <= sp_hit;
        s1_sp_val <= sp_val;

        s2_sign   <= s1_sign;
        s2_sub    <= s1_sub;
        s2_exp    <= s1_exp;
        s2_big    <= {s1_mbig, 3'b000};
        s2_sml    <= aligned;
        s2_sp_hit <= s1_sp_hit;
        s2_sp_val <= s1_sp_val;

        s3_sign   <= s2_sign;
        s3_exp    <= s2_exp;
        s3_sum    <= s2_sub ? ({1'b0, s2_big} - {1'b0, s2_sml})
                            : ({1'b0, s2_big} + {1'b0, s2_sml});
        s3_sp_hit <= s2_sp_hit;
        s3_sp_val <= s2_sp_val;

        dly_val[0] <= packed_val;
        for (int i = 1; i < DLY; i++) begin
            dly_val[i] <= dly_val[i-1];
        end
    end

    assign result       = dly_val[DLY-1];
    assign result_ready = dly_vld[DLY-1];

endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SETUP | launch the four lanes on (accumulator, operand)
// ADD   | wait for result_ready, then write accumulators and pulse done
module accumulator_2x2 #(
    parameter int ADD_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] i_a11,
    input  logic [31:0] i_a12,
    input  logic [31:0] i_a21,
    input  logic [31:0] i_a22,
    output logic [31:0] o_a11,
    output logic [31:0] o_a12,
    output logic [31:0] o_a21,
    output logic [31:0] o_a22,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SETUP, ADD} state_t;

    state_t           state, state_next;
    logic             capture, launch, accept;
    logic [3:0][31:0] acc, opnd, sum;
    logic [3:0]       ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        launch     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                launch     = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                if (&ready) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            opnd <= {i_a22, i_a21, i_a12, i_a11};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            done <= 1'b0;
        end else begin
            done <= accept;
            if (accept) begin
                acc <= sum;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        fp_add_lane #(.ADD_LAT(ADD_LAT)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .launch       (launch),
            .a            (acc[g]),
            .b            (opnd[g]),
            .result       (sum[g]),
            .result_ready (ready[g])
        );
    end

    assign o_a11 = acc[0];
    assign o_a12 = acc[1];
    assign o_a21 = acc[2];
    assign o_a22 = acc[3];

endmodule

// File: tb/tb_accumulator_2x2.sv
// Bench for accumulator_2x2: directed vectors, expected sums queued at issue
// time and checked by a negedge monitor whenever done is seen.

module tb_accumulator_2x2;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] i_a11 = '0, i_a12 = '0, i_a21 = '0, i_a22 = '0;
    logic [31:0] o_a11, o_a12, o_a21, o_a22;
    logic        done;

    typedef struct {
        logic [3:0][31:0] e;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    logic [3:0][31:0] cur, prev_o;
    logic             prev_rst = 1'b1;
    exp_t             it;
    string            lname[4] = '{"o_a11", "o_a12", "o_a21", "o_a22"};
    logic [3:0][31:0] hexp[3];
    exp_t             ht;
    int               hn;

    accumulator_2x2 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .i_a11 (i_a11),
        .i_a12 (i_a12),
        .i_a21 (i_a21),
        .i_a22 (i_a22),
        .o_a11 (o_a11),
        .o_a12 (o_a12),
        .o_a21 (o_a21),
        .o_a22 (o_a22),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        cur = {o_a22, o_a21, o_a12, o_a11};
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, no result pending", cyc);
            end else begin
                it = sb.pop_front();
                chk("done_cycle", cyc, it.cyc);
                for (int i = 0; i < 4; i++) chk(lname[i], cur[i], it.e[i]);
            end
        end else if (!prev_rst) begin
            for (int i = 0; i < 4; i++) chk("hold", cur[i], prev_o[i]);
        end
        prev_rst = reset;
        prev_o   = cur;
    end

    task automatic set_in(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        i_a11 = a;
        i_a12 = b;
        i_a21 = c;
        i_a22 = d;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] w,
                         input bit expect_done);
        exp_t t;
        set_in(a, b, c, d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        set_in(32'hA5A5A5A5, 32'h7F800000, 32'h3F800000, 32'hC1200000);
        if (expect_done) begin
            t.e   = {w, z, y, x};
            t.cyc = cyc + LAT;
            sb.push_back(t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results still pending, want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_o_a11", o_a11, 32'h0);
        chk("reset_o_a12", o_a12, 32'h0);
        chk("reset_o_a21", o_a21, 32'h0);
        chk("reset_o_a22", o_a22, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hexp[0] = {32'hBF800000, 32'h40000000, 32'h3F800000, 32'h41F0F5C3};
        hexp[1] = {32'hC0000000, 32'h40800000, 32'h40000000, 32'h4270F5C3};
        hexp[2] = {32'hC0400000, 32'h40C00000, 32'h40400000, 32'h42B4B852};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic accumulation, doubling, exact cancellation.
        issue(32'h41F0F5C3, 32'h42EE999A, 32'h3EE66666, 32'h4158A3D7,
              32'h41F0F5C3, 32'h42EE999A, 32'h3EE66666, 32'h4158A3D7, 1);
        drain();
        issue(32'h41F0F5C3, 32'h42EE999A, 32'h3EE66666, 32'h4158A3D7,
              32'h4270F5C3, 32'h436E999A, 32'h3F666666, 32'h41D8A3D7, 1);
        drain();
        issue(32'hC270F5C3, 32'h00000000, 32'h00000000, 32'h00000000,
              32'h00000000, 32'h436E999A, 32'h3F666666, 32'h41D8A3D7, 1);
        drain();

        // Rounding ties, overflow, inf - inf.
        do_reset();
        issue(32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
              32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 1);
        drain();
        issue(32'h33800000, 32'h34000000, 32'h7F7FFFFF, 32'hFF800000,
              32'h3F800000, 32'h3F800001, 32'h7F800000, 32'h7FC00000, 1);
        drain();

        // Signed zeros, NaN, subtraction, subnormal flush, ignored start.
        do_reset();
        issue(32'h80000000, 32'h3F800000, 32'h40000000, 32'h7FC00001,
              32'h00000000, 32'h3F800000, 32'h40000000, 32'h7FC00000, 1);
        drain();
        issue(32'h3F800000, 32'h80000000, 32'hC0000000, 32'h3F800000,
              32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7FC00000, 1);
        drain();
        issue(32'h40000000, 32'h3F000000, 32'h3F800000, 32'h00000000,
              32'h40400000, 32'h3FC00000, 32'h3F800000, 32'h7FC00000, 1);
        drain();
        issue(32'hBF800000, 32'hBF400000, 32'h00000001, 32'h3F800000,
              32'h40000000, 32'h3F400000, 32'h3F800000, 32'h7FC00000, 1);
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              32'h0, 32'h0, 32'h0, 32'h0, 0);
        drain();

        // Start held for 20 edges; inputs are garbage except on accepting edges.
        do_reset();
        hn    = 0;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1 || i == 8 || i == 15)
                set_in(32'h41F0F5C3, 32'h3F800000, 32'h40000000, 32'hBF800000);
            else
                set_in(32'h12345678, 32'h7FC00000, 32'hDEADBEEF, 32'h00800000);
            @(posedge clk);
            #1;
            if (i == 1 || i == 8 || i == 15) begin
                ht.e   = hexp[hn];
                ht.cyc = cyc + LAT;
                sb.push_back(ht);
                hn++;
            end
        end
        start = 1'b0;
        drain();

        // Reset during ADD aborts the addition and clears the sums.
        do_reset();
        issue(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1);
        drain();
        issue(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
              32'h0, 32'h0, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        issue(32'h40400000, 32'hC0400000, 32'h3F000000, 32'h00000000,
              32'h40400000, 32'hC0400000, 32'h3F000000, 32'h00000000, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
